// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM scan/lookup front-end: FSM encoding,
// entry field layout helpers and a constant clog2.
package tcam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } tcam_state_e;

    // Entry layout, LSB first: action, value, mask, vld.
    localparam int ACT_LSB = 0;

    function automatic int tcam_val_lsb(input int act_w);
        return act_w;
    endfunction

    function automatic int tcam_msk_lsb(input int key_w, input int act_w);
        return act_w + key_w;
    endfunction

    function automatic int tcam_vld_bit(input int key_w, input int act_w);
        return act_w + 2 * key_w;
    endfunction

    // Address width for a table of the given depth; never less than one bit.
    function automatic int tcam_clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        if (res < 1) begin
            res = 1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/tcam_entry_cmp.sv
// Combinational ternary compare of one table entry against the search key.
// A mask bit of 1 means the key bit must equal the value bit.
module tcam_entry_cmp
    import tcam_pkg::*;
#(
    parameter int KEY_WIDTH = 32,
    parameter int ACT_WIDTH = 8,
    parameter int EW        = 1 + 2 * KEY_WIDTH + ACT_WIDTH
) (
    input  logic [EW-1:0]        entry_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    output logic                 hit_o,
    output logic [ACT_WIDTH-1:0] action_o
);

    localparam int VAL_LSB = tcam_val_lsb(ACT_WIDTH);
    localparam int MSK_LSB = tcam_msk_lsb(KEY_WIDTH, ACT_WIDTH);
    localparam int VLD_BIT = tcam_vld_bit(KEY_WIDTH, ACT_WIDTH);

    logic                 vld_s;
    logic [KEY_WIDTH-1:0] mask_s;
    logic [KEY_WIDTH-1:0] value_s;

    assign vld_s    = entry_i[VLD_BIT];
    assign mask_s   = entry_i[MSK_LSB +: KEY_WIDTH];
    assign value_s  = entry_i[VAL_LSB +: KEY_WIDTH];
    assign hit_o    = vld_s & ((key_i & mask_s) == (value_s & mask_s));
    assign action_o = entry_i[ACT_LSB +: ACT_WIDTH];

endmodule

// File: rtl/tcam_scan_lookup.sv
// TCAM search front-end: scans the external rule RAM two entries per cycle
// (port B even, port C odd), keeps the lowest-index hit and returns it over
// valid/ready. Config writes are forwarded to RAM port A while idle.
module tcam_scan_lookup
    import tcam_pkg::*;
#(
    parameter int                   KEY_WIDTH      = 32,
    parameter int                   ACT_WIDTH      = 8,
    parameter int                   DEPTH          = 16,
    parameter int                   RD_LAT         = 1,
    parameter logic [ACT_WIDTH-1:0] DEFAULT_ACTION = '0,
    parameter int                   AW             = tcam_clog2(DEPTH),
    parameter int                   EW             = 1 + 2 * KEY_WIDTH + ACT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_key_valid,
    output logic                 s_key_ready,
    input  logic [KEY_WIDTH-1:0] s_key,
    output logic                 m_res_valid,
    input  logic                 m_res_ready,
    output logic                 m_res_hit,
    output logic [AW-1:0]        m_res_idx,
    output logic [ACT_WIDTH-1:0] m_res_action,
    input  logic                 cfg_wr_en,
    output logic                 cfg_wr_ready,
    input  logic [AW-1:0]        cfg_wr_addr,
    input  logic [EW-1:0]        cfg_wr_data,
    output logic                 ram_wea,
    output logic [AW-1:0]        ram_addra,
    output logic [EW-1:0]        ram_dina,
    output logic                 ram_enb,
    output logic [AW-1:0]        ram_addrb,
    input  logic [EW-1:0]        ram_doutb,
    output logic                 ram_enc,
    output logic [AW-1:0]        ram_addrc,
    input  logic [EW-1:0]        ram_doutc,
    output logic                 ram_regce
);

    localparam logic [AW-1:0] LAST_PAIR  = AW'(DEPTH / 2 - 1);
    localparam logic [3:0]    LAST_DRAIN = 4'(RD_LAT - 1);

    tcam_state_e          state_q, state_d;
    logic [AW-1:0]        pair_q, pair_d;
    logic [3:0]           drain_q, drain_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 best_hit_q, best_hit_d;
    logic [AW-1:0]        best_idx_q, best_idx_d;
    logic [ACT_WIDTH-1:0] best_act_q, best_act_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_hit_q, res_hit_d;
    logic [AW-1:0]        res_idx_q, res_idx_d;
    logic [ACT_WIDTH-1:0] res_act_q, res_act_d;
    // Read tags: stage RD_LAT-1 lines up with data on the RAM outputs.
    logic                 tag_vld_q [RD_LAT];
    logic                 tag_vld_d [RD_LAT];
    logic [AW-1:0]        tag_pair_q [RD_LAT];
    logic [AW-1:0]        tag_pair_d [RD_LAT];

    logic                 hit_b_s, hit_c_s;
    logic [ACT_WIDTH-1:0] act_b_s, act_c_s;
    logic [AW-1:0]        idx_b_s, idx_c_s;

    tcam_entry_cmp #(.KEY_WIDTH(KEY_WIDTH), .ACT_WIDTH(ACT_WIDTH), .EW(EW)) u_cmp_b (
        .entry_i (ram_doutb),
        .key_i   (key_q),
        .hit_o   (hit_b_s),
        .action_o(act_b_s)
    );

    tcam_entry_cmp #(.KEY_WIDTH(KEY_WIDTH), .ACT_WIDTH(ACT_WIDTH), .EW(EW)) u_cmp_c (
        .entry_i (ram_doutc),
        .key_i   (key_q),
        .hit_o   (hit_c_s),
        .action_o(act_c_s)
    );

    assign idx_b_s = tag_pair_q[RD_LAT-1] << 1;
    assign idx_c_s = (tag_pair_q[RD_LAT-1] << 1) | AW'(1);

    assign m_res_valid  = res_valid_q;
    assign m_res_hit    = res_hit_q;
    assign m_res_idx    = res_idx_q;
    assign m_res_action = res_act_q;

    // Next-state, best-match merge, tag pipeline and RAM/handshake outputs.
    always_comb begin
        state_d     = state_q;
        pair_d      = pair_q;
        drain_d     = drain_q;
        key_d       = key_q;
        best_hit_d  = best_hit_q;
        best_idx_d  = best_idx_q;
        best_act_d  = best_act_q;
        res_valid_d = res_valid_q;
        res_hit_d   = res_hit_q;
        res_idx_d   = res_idx_q;
        res_act_d   = res_act_q;
        s_key_ready  = 1'b0;
        cfg_wr_ready = 1'b0;
        ram_wea      = 1'b0;
        ram_addra    = '0;
        ram_dina     = '0;
        ram_enb      = 1'b0;
        ram_enc      = 1'b0;
        ram_addrb    = '0;
        ram_addrc    = '0;
        ram_regce    = 1'b0;

        tag_vld_d[0]  = (state_q == ST_SCAN);
        tag_pair_d[0] = pair_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_pair_d[i] = tag_pair_q[i-1];
        end
        for (int i = 0; i < RD_LAT; i++) begin
            ram_regce = ram_regce | tag_vld_q[i];
        end

        // First hit sticks; port B holds the lower index of the pair.
        if (tag_vld_q[RD_LAT-1] && !best_hit_q) begin
            if (hit_b_s) begin
                best_hit_d = 1'b1;
                best_idx_d = idx_b_s;
                best_act_d = act_b_s;
            end else if (hit_c_s) begin
                best_hit_d = 1'b1;
                best_idx_d = idx_c_s;
                best_act_d = act_c_s;
            end else begin
                best_hit_d = best_hit_q;
            end
        end else begin
            best_hit_d = best_hit_q;
        end

        case (state_q)
            ST_IDLE: begin
                cfg_wr_ready = 1'b1;
                s_key_ready  = !cfg_wr_en;
                if (cfg_wr_en) begin
                    ram_wea   = 1'b1;
                    ram_addra = cfg_wr_addr;
                    ram_dina  = cfg_wr_data;
                end else begin
                    ram_wea = 1'b0;
                end
                if (s_key_valid && s_key_ready) begin
                    key_d      = s_key;
                    best_hit_d = 1'b0;
                    best_idx_d = '0;
                    best_act_d = DEFAULT_ACTION;
                    pair_d     = '0;
                    state_d    = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                ram_enb   = 1'b1;
                ram_enc   = 1'b1;
                ram_addrb = pair_q << 1;
                ram_addrc = (pair_q << 1) | AW'(1);
                if (pair_q == LAST_PAIR) begin
                    drain_d = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    pair_d = pair_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = ST_RESULT;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            ST_RESULT: begin
                // First RESULT cycle registers the final best match.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_hit_d   = best_hit_q;
                    res_idx_d   = best_idx_q;
                    res_act_d   = best_act_q;
                end else if (m_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pair_q      <= '0;
            drain_q     <= 4'd0;
            key_q       <= '0;
            best_hit_q  <= 1'b0;
            best_idx_q  <= '0;
            best_act_q  <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_idx_q   <= '0;
            res_act_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= 1'b0;
                tag_pair_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            drain_q     <= drain_d;
            key_q       <= key_d;
            best_hit_q  <= best_hit_d;
            best_idx_q  <= best_idx_d;
            best_act_q  <= best_act_d;
            res_valid_q <= res_valid_d;
            res_hit_q   <= res_hit_d;
            res_idx_q   <= res_idx_d;
            res_act_q   <= res_act_d;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_vld_q[i]  <= tag_vld_d[i];
                tag_pair_q[i] <= tag_pair_d[i];
            end
        end
    end

endmodule
